// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit layout and transmitter FSM encoding for the MMIO UART.
// Pure definitions; no logic, no latency, no flow control.
package uart_pkg;

  localparam logic [3:0] ADDR_TXDATA  = 4'h0;
  localparam logic [3:0] ADDR_STATUS  = 4'h4;
  localparam logic [3:0] ADDR_BAUDDIV = 4'h8;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with show-ahead output; push/pop take effect on the rising edge.
// A push while full is dropped unless a pop happens on the same edge; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bytes written to TXDATA are queued and serialised on uart_tx.
// Reads are combinational; a write into an idle empty FIFO starts the frame one edge later; a full FIFO drops writes and sets overflow.
module mmio_uart_tx #(
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int DIV_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        uart_tx,
  output logic        irq_empty
);

  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             sel_tx;
  logic             sel_st;
  logic             sel_bd;
  logic             push;
  logic             pop;
  logic [7:0]       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;

  logic [DIV_W-1:0] bauddiv;
  logic [DIV_W-1:0] wr_div;
  logic             overflow;

  state_t           state, state_n;
  logic [7:0]       shifter, shifter_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_act, div_n;
  logic             tx_q, tx_n;
  logic             start_frame;

  logic             unused_bits;

  // Only the word offset matters; byte-lane bits and the upper data bits are don't-care.
  assign unused_bits = ^{bus_addr[1:0], bus_wdata};

  assign sel_tx = (bus_addr[3:2] == ADDR_TXDATA[3:2]);
  assign sel_st = (bus_addr[3:2] == ADDR_STATUS[3:2]);
  assign sel_bd = (bus_addr[3:2] == ADDR_BAUDDIV[3:2]);
  assign push   = bus_we && sel_tx;
  assign wr_div = (bus_wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : bus_wdata[DIV_W-1:0];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (bus_wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bauddiv  <= DIV_W'(CLKS_PER_BIT);
      overflow <= 1'b0;
    end else begin
      if (bus_we && sel_bd) bauddiv <= wr_div;
      if (push && fifo_full && !pop) begin
        overflow <= 1'b1;
      end else if (bus_we && sel_st && bus_wdata[STAT_OVF]) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shifter <= '0;
      bit_idx <= '0;
      cnt     <= '0;
      div_act <= DIV_W'(CLKS_PER_BIT);
      tx_q    <= 1'b1;
    end else begin
      state   <= state_n;
      shifter <= shifter_n;
      bit_idx <= bit_idx_n;
      cnt     <= cnt_n;
      div_act <= div_n;
      tx_q    <= tx_n;
    end
  end

  always_comb begin
    state_n     = state;
    shifter_n   = shifter;
    bit_idx_n   = bit_idx;
    cnt_n       = cnt;
    div_n       = div_act;
    tx_n        = tx_q;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (cnt == '0) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          tx_n      = shifter[0];
          cnt_n     = div_act - 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = div_act - 1'b1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            shifter_n = {1'b0, shifter[7:1]};
            tx_n      = shifter[1];
            bit_idx_n = bit_idx + 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_n     = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // The divisor is captured here so BAUDDIV writes never disturb a frame in flight.
    if (start_frame) begin
      state_n   = START;
      shifter_n = fifo_dout;
      tx_n      = 1'b0;
      div_n     = bauddiv;
      cnt_n     = bauddiv - 1'b1;
    end
  end

  assign pop       = start_frame;
  assign uart_tx   = tx_q;
  assign irq_empty = fifo_empty && (state == IDLE);

  always_comb begin
    bus_rdata = '0;
    if (bus_re) begin
      if (sel_st) begin
        bus_rdata[STAT_FULL]                   = fifo_full;
        bus_rdata[STAT_EMPTY]                  = fifo_empty;
        bus_rdata[STAT_BUSY]                   = (state != IDLE);
        bus_rdata[STAT_OVF]                    = overflow;
        bus_rdata[STAT_CNT_LSB +: STAT_CNT_W]  = STAT_CNT_W'(fifo_count);
      end else if (sel_bd) begin
        bus_rdata[DIV_W-1:0] = bauddiv;
      end
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register table, then frame-level scoreboard against a cycle-exact line receiver.
module tb_mmio_uart_tx;

  logic        clk;
  logic        reset;
  logic [3:0]  bus_addr;
  logic        bus_we;
  logic        bus_re;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        uart_tx;
  logic        irq_empty;

  mmio_uart_tx #(
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (4),
    .DIV_W        (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .uart_tx   (uart_tx),
    .irq_empty (irq_empty)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       abort;
  } sb_t;

  typedef struct {
    logic ok;
    logic aborted;
    int   start;
  } rx_rec_t;

  typedef struct {
    logic        we;
    logic        re;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  sb_t     sb_q[$];
  rx_rec_t res_q[$];
  vec_t    vecs[18];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   res_chk = 0;
  int   rx_idx = 0;
  logic rx_busy = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  // Line receiver: on a start bit, checks every cycle of the frame against the next scoreboard entry.
  initial begin : rx
    rx_rec_t    r;
    int         d;
    int         k;
    logic [7:0] e;
    logic       eb;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && uart_tx === 1'b0) begin
        r.start   = cyc;
        r.ok      = 1'b1;
        r.aborted = 1'b0;
        if (rx_idx >= sb_q.size()) begin
          r.ok = 1'b0;
          d    = 4;
          e    = 8'h00;
        end else begin
          d = sb_q[rx_idx].div;
          e = sb_q[rx_idx].data;
        end
        rx_busy = 1'b1;
        for (int j = 0; j < 10 * d; j++) begin
          if (j > 0) @(negedge clk);
          if (reset !== 1'b1) begin
            r.aborted = 1'b1;
            r.ok      = 1'b0;
            break;
          end
          k  = j / d;
          eb = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : e[k-1];
          if (uart_tx !== eb) r.ok = 1'b0;
        end
        res_q.push_back(r);
        rx_idx++;
        rx_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_access(input logic we, input logic re, input logic [3:0] a,
                            input logic [31:0] d, output logic [31:0] rd);
    bus_we    = we;
    bus_re    = re;
    bus_addr  = a;
    bus_wdata = d;
    #1;
    rd = bus_rdata;
    @(posedge clk);
    #1;
    if (we) last_wr_cyc = cyc;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    bus_addr  = 4'h0;
    bus_wdata = 32'h0;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] unused_rd;
    bus_access(1'b1, 1'b0, a, d, unused_rd);
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] rd);
    bus_access(1'b0, 1'b1, a, 32'h0, rd);
  endtask

  task automatic send(input logic [7:0] b, input int div);
    sb_q.push_back('{b, div, 1'b0});
    bus_wr(4'h0, {24'h0, b});
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!(irq_empty === 1'b1 && !rx_busy && res_q.size() == sb_q.size()) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_in_budget", 32'(n < limit), 32'd1);
  endtask

  task automatic check_frames();
    while (res_chk < res_q.size()) begin
      if (res_chk < sb_q.size() && sb_q[res_chk].abort)
        check($sformatf("frame%0d_aborted", res_chk), 32'(res_q[res_chk].aborted), 32'd1);
      else
        check($sformatf("frame%0d_shape", res_chk), 32'(res_q[res_chk].ok), 32'd1);
      res_chk++;
    end
  endtask

  function automatic int gap(input int idx);
    if (idx + 1 < res_q.size()) return res_q[idx+1].start - res_q[idx].start;
    return -1;
  endfunction

  initial begin : main
    logic [31:0] rd;
    int          idx;
    int          c0;
    int          viol;

    bus_addr = 4'h0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = 32'h0;
    reset = 1'b1;
    #2 reset = 1'b0;

    vecs[0]  = '{1'b0, 1'b1, 4'h4, 32'h0,         32'h0000_0002};
    vecs[1]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_0004};
    vecs[2]  = '{1'b0, 1'b1, 4'h0, 32'h0,         32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, 4'hC, 32'h0,         32'h0000_0000};
    vecs[4]  = '{1'b0, 1'b0, 4'h4, 32'h0,         32'h0000_0000};
    vecs[5]  = '{1'b0, 1'b1, 4'h6, 32'h0,         32'h0000_0002};
    vecs[6]  = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h0000_0000};
    vecs[7]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_0001};
    vecs[8]  = '{1'b1, 1'b0, 4'h8, 32'h0001_2345, 32'h0000_0000};
    vecs[9]  = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_2345};
    vecs[10] = '{1'b1, 1'b0, 4'hC, 32'h0000_FFFF, 32'h0000_0000};
    vecs[11] = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_2345};
    vecs[12] = '{1'b1, 1'b1, 4'h4, 32'hFFFF_FFF7, 32'h0000_0002};
    vecs[13] = '{1'b0, 1'b1, 4'h4, 32'h0,         32'h0000_0002};
    vecs[14] = '{1'b1, 1'b0, 4'hB, 32'h0000_0005, 32'h0000_0000};
    vecs[15] = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_0005};
    vecs[16] = '{1'b1, 1'b0, 4'h8, 32'h0000_0004, 32'h0000_0000};
    vecs[17] = '{1'b0, 1'b1, 4'h8, 32'h0,         32'h0000_0004};

    repeat (3) @(posedge clk);
    #1;
    bus_re = 1'b1; bus_addr = 4'h4;
    #1;
    check("reset_tx", 32'(uart_tx), 32'd1);
    check("reset_irq", 32'(irq_empty), 32'd1);
    check("reset_status_in_reset", bus_rdata, 32'h0000_0002);
    bus_re = 1'b0;
    #1;
    check("reset_rdata", bus_rdata, 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 18; i++) begin
      bus_access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("vec%0d", i), rd, vecs[i].exp);
    end

    // Single byte: start bit lands one edge after the write; irq returns after the stop bit.
    idx = sb_q.size();
    send(8'h55, 4);
    c0 = last_wr_cyc;
    repeat (41) @(negedge clk);
    check("irq_during_stop", 32'(irq_empty), 32'd0);
    @(negedge clk);
    check("irq_after_stop", 32'(irq_empty), 32'd1);
    wait_idle(500);
    check_frames();
    check("start_latency", 32'(res_q[idx].start), 32'(c0 + 1));

    // Back-to-back frames: second start bit immediately follows the first stop bit.
    idx = sb_q.size();
    send(8'hA5, 4);
    send(8'h3C, 4);
    wait_idle(1000);
    check_frames();
    check("b2b_gap", 32'(gap(idx)), 32'd40);

    // Overflow: six writes into a four-entry FIFO while the first byte is on the wire.
    for (int b = 1; b <= 6; b++) begin
      if (b <= 5) sb_q.push_back('{8'(b), 4, 1'b0});
      bus_wr(4'h0, 32'(b));
      if (b == 1) c0 = last_wr_cyc;
    end
    bus_rd(4'h4, rd);
    check("ovf_status", rd, 32'h0000_040D);
    bus_access(1'b1, 1'b1, 4'h4, 32'h0000_0008, rd);
    check("status_pre_edge", rd, 32'h0000_040D);
    bus_rd(4'h4, rd);
    check("ovf_cleared", rd, 32'h0000_0405);
    // Push on the edge where the stop bit ends and the head is popped while full.
    while (cyc != c0 + 40) begin
      @(posedge clk);
      #1;
    end
    sb_q.push_back('{8'h07, 4, 1'b0});
    bus_wr(4'h0, 32'h07);
    bus_rd(4'h4, rd);
    check("full_push_with_pop", rd, 32'h0000_0405);
    wait_idle(2000);
    check_frames();

    // Divisor: 0 reads back as 1; a mid-frame change only affects the following frame.
    bus_wr(4'h8, 32'h0);
    bus_rd(4'h8, rd);
    check("div_zero_is_one", rd, 32'h1);
    send(8'hC3, 1);
    wait_idle(500);
    check_frames();
    bus_wr(4'h8, 32'h4);
    idx = sb_q.size();
    send(8'h96, 4);
    repeat (10) @(posedge clk);
    #1;
    bus_wr(4'h8, 32'h8);
    send(8'h5A, 8);
    wait_idle(2000);
    check_frames();
    check("div_old_rate_kept", 32'(gap(idx)), 32'd40);

    // Reset in the middle of a frame of zeros.
    bus_wr(4'h8, 32'h6);
    sb_q.push_back('{8'h00, 6, 1'b1});
    bus_wr(4'h0, 32'h0);
    repeat (10) @(posedge clk);
    #3;
    check("tx_low_before_reset", 32'(uart_tx), 32'd0);
    reset = 1'b0;
    #1;
    check("tx_async_reset", 32'(uart_tx), 32'd1);
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) viol++;
    end
    check("tx_high_in_reset", 32'(viol), 32'd0);
    check("irq_in_reset", 32'(irq_empty), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus_rd(4'h4, rd);
    check("status_after_reset", rd, 32'h0000_0002);
    bus_rd(4'h8, rd);
    check("bauddiv_after_reset", rd, 32'h0000_0004);
    send(8'hE7, 4);
    wait_idle(500);
    check_frames();
    check("frames_total", 32'(res_q.size()), 32'(sb_q.size()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
